// File: rtl/tpu_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tpu_bus_arbiter
// Description : Round-robin owner selection for the shared TPU data bus, with
//               burst-length grants and a forced idle turnaround between owners.
//               Optional macro BUS_ARB_PRIO_EN adds a prio_mode input that
//               selects fixed lowest-index-wins priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_bus_arbiter #(
    parameter int R          = 3,
    parameter int LW         = 4,
    parameter int TURNAROUND = 1
) (
    input  logic                 s_clk,
    input  logic                 s_rst,
    input  logic [R-1:0]         req,
    input  logic [R*LW-1:0]      req_len,
`ifdef BUS_ARB_PRIO_EN
    input  logic                 prio_mode,
`endif
    output logic [R-1:0]         grant,
    output logic [$clog2(R)-1:0] owner,
    output logic                 busy,
    output logic [R-1:0]         done
);

    localparam int IW = $clog2(R);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_grant = 2'd1;
    localparam logic [1:0] c_st_turn  = 2'd2;

    localparam logic [1:0]   c_turn_init = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;
    localparam logic [R-1:0] c_one       = {{(R-1){1'b0}}, 1'b1};

    // Index base+k reduced modulo R; k never exceeds R, so one subtraction suffices.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= R) begin
            s = s - R;
        end
        return IW'(s);
    endfunction

    logic [1:0]    r_state;
    logic [LW-1:0] r_cnt;
    logic [1:0]    r_tcnt;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_owner;
    logic [R-1:0]  r_grant;

    logic          w_prio;
    logic [IW-1:0] w_base;
    logic [IW-1:0] w_win;
    logic          w_found;
    logic [LW-1:0] w_len;
    logic          w_owner_req;
    logic          w_end;
    logic          w_arb;

`ifdef BUS_ARB_PRIO_EN
    assign w_prio = prio_mode;
`else
    assign w_prio = 1'b0;
`endif

    assign w_base = w_prio ? '0 : r_ptr;

    // Scan downward so the last hit kept is the one closest to the base.
    always_comb begin : p_select
        w_found = 1'b0;
        w_win   = '0;
        for (int k = R - 1; k >= 0; k--) begin
            if (req[wrap_add(w_base, k)]) begin
                w_found = 1'b1;
                w_win   = wrap_add(w_base, k);
            end
        end
    end

    assign w_len       = req_len[int'(w_win)*LW +: LW];
    assign w_owner_req = req[r_owner];

    // Early release (owner drops req) and count exhaustion both end the burst.
    assign w_end = (r_state == c_st_grant) && (!w_owner_req || (r_cnt == '0));

    assign w_arb = (r_state == c_st_idle)
                || ((r_state == c_st_turn) && (r_tcnt == 2'd0))
                || (w_end && (TURNAROUND == 0));

    always_ff @(posedge s_clk) begin : p_fsm
        if (s_rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_tcnt  <= 2'd0;
            r_ptr   <= '0;
            r_owner <= '0;
            r_grant <= '0;
        end else if (w_arb) begin
            if (w_found) begin
                r_state <= c_st_grant;
                r_grant <= c_one << w_win;
                r_owner <= w_win;
                r_cnt   <= w_len;
                if (!w_prio) begin
                    r_ptr <= wrap_add(w_win, 1);
                end
            end else begin
                r_state <= c_st_idle;
                r_grant <= '0;
            end
        end else begin
            case (r_state)
                c_st_grant: begin
                    if (w_end) begin
                        r_state <= c_st_turn;
                        r_tcnt  <= c_turn_init;
                        r_grant <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_st_turn: begin
                    r_tcnt <= r_tcnt - 1'b1;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign owner = r_owner;
    assign busy  = (r_state != c_st_idle);
    assign done  = ((r_state == c_st_grant) && (r_cnt == '0) && w_owner_req) ? r_grant : '0;

endmodule
`default_nettype wire

// File: tb/tb_tpu_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for tpu_bus_arbiter: two instances (TURNAROUND=1 and 0) share
// stimulus and are checked every cycle against an owner/remaining-cycles model.
module tb_tpu_bus_arbiter;

    localparam int R  = 3;
    localparam int LW = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [R-1:0]  req = '0;
    logic [R*LW-1:0] req_len = '0;
    logic          prio_eff;
    int checks   = 0;
    int failures = 0;

`ifdef BUS_ARB_PRIO_EN
    logic prio_mode = 1'b0;
    assign prio_eff = prio_mode;
`else
    assign prio_eff = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // First requester at or after base in circular order, or -1.
    function automatic int pick(input int base);
        for (int k = 0; k < R; k++) begin
            if (req[(base + k) % R]) return (base + k) % R;
        end
        return -1;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int TA = (gi == 0) ? 1 : 0;
        logic [R-1:0]  grant;
        logic [R-1:0]  done;
        logic [IW-1:0] owner;
        logic          busy;

        tpu_bus_arbiter #(.R(R), .LW(LW), .TURNAROUND(TA)) u_dut (
            .s_clk   (clk),
            .s_rst   (rst),
            .req     (req),
            .req_len (req_len),
`ifdef BUS_ARB_PRIO_EN
            .prio_mode(prio_mode),
`endif
            .grant   (grant),
            .owner   (owner),
            .busy    (busy),
            .done    (done)
        );

        // Model: owner (-1 = nobody), cycles left in burst, idle cycles left.
        int m_own  = -1;
        int m_left = 0;
        int m_gap  = 0;
        int m_last = 0;
        int m_ptr  = 0;

        always @(posedge clk) begin : p_model
            int own, left, gap, last, ptr, w;
            logic arb;
            own = m_own; left = m_left; gap = m_gap; last = m_last; ptr = m_ptr;
            arb = 1'b0;
            if (rst) begin
                own = -1; left = 0; gap = 0; last = 0; ptr = 0;
            end else if (own >= 0) begin
                if (req[own] == 1'b0 || left == 1) begin
                    own = -1;
                    if (TA > 0) gap = TA;
                    else        arb = 1'b1;
                end else begin
                    left--;
                end
            end else if (gap > 0) begin
                gap--;
                if (gap == 0) arb = 1'b1;
            end else begin
                arb = 1'b1;
            end
            if (arb) begin
                w = pick(prio_eff ? 0 : ptr);
                if (w >= 0) begin
                    own  = w;
                    left = int'(req_len[w*LW +: LW]) + 1;
                    last = w;
                    if (!prio_eff) ptr = (w + 1) % R;
                end
            end
            m_own <= own; m_left <= left; m_gap <= gap; m_last <= last; m_ptr <= ptr;
        end

        always @(negedge clk) begin : p_compare
            logic [R-1:0] eg, ed;
            eg = '0;
            if (m_own >= 0) eg[m_own] = 1'b1;
            ed = (m_own >= 0 && m_left == 1 && req[m_own]) ? eg : '0;
            chk($sformatf("i%0d grant", gi), 32'(grant), 32'(eg));
            chk($sformatf("i%0d done", gi), 32'(done), 32'(ed));
            chk($sformatf("i%0d busy", gi), 32'(busy), 32'(m_own >= 0 || m_gap > 0));
            chk($sformatf("i%0d owner", gi), 32'(owner), 32'(m_last));
            chk($sformatf("i%0d onehot", gi), 32'($countones(grant) <= 1), 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        req_len = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin : p_stim
        // Reset state, then a 3-cycle burst on driver 0.
        do_reset();
        chk("rst grant", 32'(g_inst[0].grant), 32'd0);
        chk("rst busy",  32'(g_inst[0].busy),  32'd0);
        chk("rst owner", 32'(g_inst[0].owner), 32'd0);
        req = 3'b001; req_len = 12'h002;
        step(); chk("t1 c1 grant", 32'(g_inst[0].grant), 32'b001);
        chk("t1 c1 done", 32'(g_inst[0].done), 32'd0);
        step(); chk("t1 c2 grant", 32'(g_inst[0].grant), 32'b001);
        step(); chk("t1 c3 grant", 32'(g_inst[0].grant), 32'b001);
        chk("t1 c3 done", 32'(g_inst[0].done), 32'b001);
        step(); chk("t1 c4 grant", 32'(g_inst[0].grant), 32'd0);
        chk("t1 c4 busy", 32'(g_inst[0].busy), 32'd1);
        req = '0;
        step(); chk("t1 c5 busy", 32'(g_inst[0].busy), 32'd0);

        // Full round robin with single-cycle bursts.
        do_reset();
        req = 3'b111; req_len = '0;
        step(); chk("t2 c1 grant", 32'(g_inst[0].grant), 32'b001);
        chk("t2 c1 done", 32'(g_inst[0].done), 32'b001);
        step(); chk("t2 c2 grant", 32'(g_inst[0].grant), 32'b000);
        step(); chk("t2 c3 grant", 32'(g_inst[0].grant), 32'b010);
        chk("t2 c3 owner", 32'(g_inst[0].owner), 32'd1);
        step(); chk("t2 c4 grant", 32'(g_inst[0].grant), 32'b000);
        step(); chk("t2 c5 grant", 32'(g_inst[0].grant), 32'b100);
        chk("t2 c5 owner", 32'(g_inst[0].owner), 32'd2);
        step(); step(); chk("t2 c7 grant", 32'(g_inst[0].grant), 32'b001);

        // Early release: no done pulse.
        do_reset();
        req = 3'b010; req_len = 12'h070;
        step(); chk("t3 c1 grant", 32'(g_inst[0].grant), 32'b010);
        step(); chk("t3 c2 grant", 32'(g_inst[0].grant), 32'b010);
        step(); chk("t3 c3 grant", 32'(g_inst[0].grant), 32'b010);
        chk("t3 c3 done", 32'(g_inst[0].done), 32'd0);
        req = '0;
        step(); chk("t3 c4 grant", 32'(g_inst[0].grant), 32'd0);
        chk("t3 c4 done", 32'(g_inst[0].done), 32'd0);

        // Reset mid-burst, then first grant goes to lowest index.
        do_reset();
        req = 3'b100; req_len = 12'h700;
        step(); chk("t4 c1 grant", 32'(g_inst[0].grant), 32'b100);
        step(); rst = 1'b1;
        step(); chk("t4 c3 grant", 32'(g_inst[0].grant), 32'd0);
        chk("t4 c3 busy", 32'(g_inst[0].busy), 32'd0);
        chk("t4 c3 owner", 32'(g_inst[0].owner), 32'd0);
        rst = 1'b0; req = 3'b111; req_len = '0;
        step(); chk("t4 c4 grant", 32'(g_inst[0].grant), 32'b001);

        // Zero turnaround instance: back-to-back owners.
        do_reset();
        req = 3'b011; req_len = 12'h011;
        step(); chk("t5 c1 grant", 32'(g_inst[1].grant), 32'b001);
        step(); chk("t5 c2 grant", 32'(g_inst[1].grant), 32'b001);
        step(); chk("t5 c3 grant", 32'(g_inst[1].grant), 32'b010);
        step(); chk("t5 c4 grant", 32'(g_inst[1].grant), 32'b010);
        step(); chk("t5 c5 grant", 32'(g_inst[1].grant), 32'b001);

        // Maximum burst length: 16 cycles.
        do_reset();
        req = 3'b001; req_len = 12'h00f;
        for (int c = 1; c <= 15; c++) step();
        chk("max c15 done", 32'(g_inst[0].done), 32'd0);
        step(); chk("max c16 grant", 32'(g_inst[0].grant), 32'b001);
        chk("max c16 done", 32'(g_inst[0].done), 32'b001);
        step(); chk("max c17 grant", 32'(g_inst[0].grant), 32'd0);

`ifdef BUS_ARB_PRIO_EN
        do_reset();
        prio_mode = 1'b1; req = 3'b111; req_len = '0;
        step(); chk("t6 c1 grant", 32'(g_inst[0].grant), 32'b001);
        step(); step(); chk("t6 c3 grant", 32'(g_inst[0].grant), 32'b001);
        prio_mode = 1'b0;
        step(); step(); chk("t6 c5 grant", 32'(g_inst[0].grant), 32'b001);
        step(); step(); chk("t6 c7 grant", 32'(g_inst[0].grant), 32'b010);
`endif

        // Randomized phase with level-held requests.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < R; b++) begin
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
                req_len[b*LW +: LW] = LW'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 15 : 2));
            end
`ifdef BUS_ARB_PRIO_EN
            if ($urandom_range(0, 63) == 0) prio_mode = ~prio_mode;
`endif
            step();
        end

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
